// File: rtl/captura_teclado.sv
// captura_teclado: keyboard entry stage in front of the data decoder.
// Filters PS/2 break/extended sequences and typematic repeats, assembles four
// make codes into shadow registers and commits them atomically on Enter.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   rx_done_tick, dout one-cycle strobe and scan code from the PS/2 receiver
//   decenas, unidades, presencia, ignicion  committed make codes
//   listo              one-cycle pulse when a frame is committed
//   campo              next field to fill (0..3), 4 = complete, awaiting Enter
module captura_teclado (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] dout,
    output logic [7:0] decenas,
    output logic [7:0] unidades,
    output logic [7:0] presencia,
    output logic [7:0] ignicion,
    output logic       listo,
    output logic [2:0] campo
);

    localparam int unsigned CODE_W   = 8;
    localparam int unsigned CAMPO_W  = 3;
    localparam int unsigned N_CAMPOS = 4;

    localparam logic [CODE_W-1:0] SC_BREAK = 8'hF0;
    localparam logic [CODE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;
    localparam logic [CODE_W-1:0] SC_BKSP  = 8'h66;
    localparam logic [CODE_W-1:0] SC_ESC   = 8'h76;

    localparam logic [CAMPO_W-1:0] CAMPO_LLENO = CAMPO_W'(N_CAMPOS);

    typedef enum logic [1:0] {
        REPOSO,
        SOLTAR,
        EXTENDIDO
    } estado_t;

    estado_t estado, estado_n;

    logic [CODE_W-1:0]                ultimo_make, ultimo_make_n;
    logic [N_CAMPOS-1:0][CODE_W-1:0]  sombra, sombra_n;
    logic [N_CAMPOS-1:0][CODE_W-1:0]  salida, salida_n;
    logic [CAMPO_W-1:0]               campo_n;
    logic                             listo_n;
    logic [1:0]                       idx_atras;

    // State and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= REPOSO;
            ultimo_make <= '0;
            sombra      <= '0;
            salida      <= '0;
            campo       <= '0;
            listo       <= 1'b0;
        end else begin
            estado      <= estado_n;
            ultimo_make <= ultimo_make_n;
            sombra      <= sombra_n;
            salida      <= salida_n;
            campo       <= campo_n;
            listo       <= listo_n;
        end
    end

    // Field index cleared by Backspace (the one just below the pointer)
    assign idx_atras = 2'(campo - 3'd1);

    // Prefix FSM, typematic filter and field editing
    always_comb begin
        estado_n      = estado;
        ultimo_make_n = ultimo_make;
        sombra_n      = sombra;
        salida_n      = salida;
        campo_n       = campo;
        listo_n       = 1'b0;

        if (rx_done_tick) begin
            unique case (estado)
                REPOSO: begin
                    if (dout == SC_BREAK) begin
                        estado_n = SOLTAR;
                    end else if (dout == SC_EXT) begin
                        estado_n = EXTENDIDO;
                    end else if (dout != ultimo_make) begin
                        ultimo_make_n = dout;
                        if (dout == SC_ESC) begin
                            sombra_n = '0;
                            campo_n  = '0;
                        end else if (dout == SC_BKSP) begin
                            if (campo != '0) begin
                                campo_n             = campo - 3'd1;
                                sombra_n[idx_atras] = '0;
                            end
                        end else if (dout == SC_ENTER) begin
                            if (campo == CAMPO_LLENO) begin
                                salida_n = sombra;
                                listo_n  = 1'b1;
                                campo_n  = '0;
                            end
                        end else if (campo < CAMPO_LLENO) begin
                            sombra_n[campo[1:0]] = dout;
                            campo_n              = campo + 3'd1;
                        end
                    end
                end
                SOLTAR: begin
                    // Released key: byte dropped, next press of any key is new
                    ultimo_make_n = '0;
                    estado_n      = REPOSO;
                end
                EXTENDIDO: begin
                    estado_n = (dout == SC_BREAK) ? SOLTAR : REPOSO;
                end
                default: begin
                    estado_n = REPOSO;
                end
            endcase
        end
    end

    assign decenas   = salida[0];
    assign unidades  = salida[1];
    assign presencia = salida[2];
    assign ignicion  = salida[3];

endmodule

// File: tb/tb_captura_teclado.sv
// Directed self-checking bench for captura_teclado.
module tb_captura_teclado;

    logic       clk;
    logic       rst;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic [7:0] decenas;
    logic [7:0] unidades;
    logic [7:0] presencia;
    logic [7:0] ignicion;
    logic       listo;
    logic [2:0] campo;

    int n_checks;
    int n_errors;

    logic [7:0] rafaga [13];

    captura_teclado dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .decenas      (decenas),
        .unidades     (unidades),
        .presencia    (presencia),
        .ignicion     (ignicion),
        .listo        (listo),
        .campo        (campo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One byte with a tick; returns at the falling edge after it took effect
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        dout         = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        dout         = 8'hXX;
    endtask

    // Make followed by break: leaves the typematic filter cleared
    task automatic press(input logic [7:0] b);
        send_byte(b);
        send_byte(8'hF0);
        send_byte(b);
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic [7:0] u,
                             input logic [7:0] p, input logic [7:0] i);
        check({tag, ".decenas"},   32'(decenas),   32'(d));
        check({tag, ".unidades"},  32'(unidades),  32'(u));
        check({tag, ".presencia"}, 32'(presencia), 32'(p));
        check({tag, ".ignicion"},  32'(ignicion),  32'(i));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        rx_done_tick = 1'b0;
        dout         = 8'h00;
        #3;
        check_out("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset.listo", 32'(listo), 32'd0);
        check("reset.campo", 32'(campo), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full entry with releases, then Enter
        send_byte(8'h25); send_byte(8'hF0); send_byte(8'h25);
        send_byte(8'h1E); send_byte(8'hF0); send_byte(8'h1E);
        send_byte(8'h4D); send_byte(8'hF0); send_byte(8'h4D);
        send_byte(8'h43); send_byte(8'hF0); send_byte(8'h43);
        check("full.campo_lleno", 32'(campo), 32'd4);
        send_byte(8'h5A);
        check("full.listo_alto", 32'(listo), 32'd1);
        check("full.campo", 32'(campo), 32'd0);
        check_out("full", 8'h25, 8'h1E, 8'h4D, 8'h43);
        @(negedge clk);
        check("full.listo_bajo", 32'(listo), 32'd0);
        send_byte(8'hF0); send_byte(8'h5A);

        // Typematic repeats collapse to one write
        send_byte(8'h26); send_byte(8'h26); send_byte(8'h26);
        send_byte(8'hF0); send_byte(8'h26);
        check("typematic.campo1", 32'(campo), 32'd1);
        send_byte(8'h26);
        check("typematic.campo2", 32'(campo), 32'd2);

        // Early Enter is ignored
        send_byte(8'h5A);
        check("early_enter.listo", 32'(listo), 32'd0);
        check("early_enter.campo", 32'(campo), 32'd2);
        check_out("early_enter", 8'h25, 8'h1E, 8'h4D, 8'h43);
        send_byte(8'hF0); send_byte(8'h5A);

        // Extended key press/release writes nothing
        send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0);
        send_byte(8'hF0); send_byte(8'h75);
        check("extended.campo", 32'(campo), 32'd2);
        // FSM must be back in REPOSO: next make code is accepted
        press(8'h1C);
        check("extended.reposo", 32'(campo), 32'd3);
        press(8'h1B);
        check("overflow.campo4", 32'(campo), 32'd4);
        press(8'h16);
        check("overflow.campo_stays", 32'(campo), 32'd4);
        send_byte(8'h5A);
        check("overflow.listo", 32'(listo), 32'd1);
        check_out("overflow", 8'h26, 8'h26, 8'h1C, 8'h1B);
        send_byte(8'hF0); send_byte(8'h5A);

        // Backspace edit
        press(8'h2E);
        press(8'h66);
        press(8'h25);
        check("backspace.campo", 32'(campo), 32'd1);
        press(8'h66);
        press(8'h66);
        check("backspace.at_zero", 32'(campo), 32'd0);
        press(8'h25);
        press(8'h3C); press(8'h44); press(8'h4B);
        send_byte(8'h5A);
        check("backspace.listo", 32'(listo), 32'd1);
        check_out("backspace", 8'h25, 8'h3C, 8'h44, 8'h4B);
        send_byte(8'hF0); send_byte(8'h5A);

        // Esc mid-entry
        press(8'h16); press(8'h1E);
        press(8'h76);
        check("esc.campo", 32'(campo), 32'd0);
        check_out("esc", 8'h25, 8'h3C, 8'h44, 8'h4B);

        // Back-to-back ticks every cycle
        rafaga = '{8'h2D, 8'hF0, 8'h2D, 8'h2C, 8'hF0, 8'h2C,
                   8'h35, 8'hF0, 8'h35, 8'h3C, 8'hF0, 8'h3C, 8'h5A};
        @(negedge clk);
        for (int k = 0; k < 13; k++) begin
            rx_done_tick = 1'b1;
            dout         = rafaga[k];
            @(negedge clk);
        end
        rx_done_tick = 1'b0;
        check("burst.listo", 32'(listo), 32'd1);
        check("burst.campo", 32'(campo), 32'd0);
        check_out("burst", 8'h2D, 8'h2C, 8'h35, 8'h3C);
        send_byte(8'hF0); send_byte(8'h5A);

        // Asynchronous reset with campo=3
        press(8'h1A); press(8'h22); press(8'h21);
        check("prereset.campo", 32'(campo), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst.campo", 32'(campo), 32'd0);
        check("async_rst.listo", 32'(listo), 32'd0);
        check_out("async_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        #1 rst = 1'b0;

        // Complete sequence after reset
        press(8'h45); press(8'h16); press(8'h1E); press(8'h26);
        send_byte(8'h5A);
        check("post_rst.listo", 32'(listo), 32'd1);
        check_out("post_rst", 8'h45, 8'h16, 8'h1E, 8'h26);
        @(negedge clk);
        check("post_rst.listo_bajo", 32'(listo), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
